modbus_frame_tx: RTL and testbench

Frame sequencer between the Modbus RTU response builder and `uart_byte_tx`. On a start pulse it reads a response payload of `frame_len` bytes from the response buffer and drives each byte into the byte transmitter with a one-cycle `tx_start` pulse, waiting for `tx_done` before sending the next byte. It computes the Modbus CRC-16 on the fly, appends it low byte first, then enforces the RTU inter-frame silent interval before it accepts the next frame.

---
 rtl/modbus_pkg.sv | 44 ++++
 rtl/modbus_frame_tx.sv | 178 +++++++++++++++++
 tb/tb_modbus_frame_tx.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/modbus_pkg.sv
// Shared definitions for the Modbus RTU frame transmitter: CRC-16 constants and
// byte-step function, one-hot state encoding and inter-frame gap default.
package modbus_pkg;

    localparam logic [15:0] CRC_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC_POLY    = 16'hA001;
    localparam int unsigned MAX_PDU_LEN = 254;

    // One-hot state encoding
    typedef enum logic [8:0] {
        StIdle     = 9'b0_0000_0001,
        StFetch    = 9'b0_0000_0010,
        StLoad     = 9'b0_0000_0100,
        StWaitData = 9'b0_0000_1000,
        StCrcLo    = 9'b0_0001_0000,
        StWaitLo   = 9'b0_0010_0000,
        StCrcHi    = 9'b0_0100_0000,
        StWaitHi   = 9'b0_1000_0000,
        StGap      = 9'b1_0000_0000
    } tx_state_e;

    // Fold one byte into a reflected Modbus CRC-16 (8 shift/XOR steps)
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // RTU silent interval: fixed 1.75 ms above 19200 baud, else 3.5 character times
    function automatic int unsigned gap_cycles_calc(input longint unsigned clk_freq,
                                                    input longint unsigned baud_rate);
        longint unsigned cycles;
        if (baud_rate > 64'd19200) begin
            cycles = clk_freq * 64'd1750 / 64'd1_000_000;
        end else begin
            cycles = clk_freq * 64'd385 / (baud_rate * 64'd10);
        end
        return 32'(cycles);
    endfunction

endpackage

// File: rtl/modbus_frame_tx.sv
// Modbus RTU frame sequencer: reads a payload from a synchronous response buffer,
// hands each byte to uart_byte_tx, appends the CRC-16 (low byte first) and then
// holds off for the inter-frame silent interval.
// Build option: define MODBUS_TX_CRC_EN to generate and append the CRC. Without it
// the caller supplies the CRC inside the payload and frame_len 0 means 256 bytes.
module modbus_frame_tx
    import modbus_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned GAP_CYCLES = gap_cycles_calc(CLK_FREQ, BAUD_RATE)
) (
    input  logic       sys_clk,
    input  logic       reset_n,
    input  logic       frame_start,
    input  logic [7:0] frame_len,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_err
);

    localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

    tx_state_e       state_q, state_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      rd_addr_q, rd_addr_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            busy_q, busy_d;
    logic            frame_done_q, frame_done_d;
    logic            frame_err_q, frame_err_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic            len_ok;
`ifdef MODBUS_TX_CRC_EN
    logic [15:0]     crc_q, crc_d;
`endif

`ifdef MODBUS_TX_CRC_EN
    assign len_ok = (frame_len != 8'd0) && (frame_len <= 8'(MAX_PDU_LEN));
`else
    // Every length is legal; 0 wraps to 256 through the len_q - 1 end test
    assign len_ok = 1'b1;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        rd_addr_d    = rd_addr_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        gap_d        = gap_q;
`ifdef MODBUS_TX_CRC_EN
        crc_d        = crc_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    if (len_ok) begin
                        len_d     = frame_len;
                        rd_addr_d = 8'd0;
                        busy_d    = 1'b1;
                        state_d   = StFetch;
`ifdef MODBUS_TX_CRC_EN
                        crc_d     = CRC_INIT;
`endif
                    end else begin
`ifdef MODBUS_TX_CRC_EN
                        frame_err_d = 1'b1;
`endif
                    end
                end
            end
            // rd_data for rd_addr_q arrives on the next cycle
            StFetch: state_d = StLoad;
            StLoad: begin
                tx_data_d  = rd_data;
                tx_start_d = 1'b1;
`ifdef MODBUS_TX_CRC_EN
                crc_d      = crc16_byte(crc_q, rd_data);
`endif
                state_d    = StWaitData;
            end
            StWaitData: begin
                if (tx_done) begin
                    if (rd_addr_q == len_q - 8'd1) begin
`ifdef MODBUS_TX_CRC_EN
                        state_d = StCrcLo;
`else
                        gap_d   = '0;
                        state_d = StGap;
`endif
                    end else begin
                        rd_addr_d = rd_addr_q + 8'd1;
                        state_d   = StFetch;
                    end
                end
            end
`ifdef MODBUS_TX_CRC_EN
            StCrcLo: begin
                tx_data_d  = crc_q[7:0];
                tx_start_d = 1'b1;
                state_d    = StWaitLo;
            end
            StWaitLo: if (tx_done) state_d = StCrcHi;
            StCrcHi: begin
                tx_data_d  = crc_q[15:8];
                tx_start_d = 1'b1;
                state_d    = StWaitHi;
            end
            StWaitHi: begin
                if (tx_done) begin
                    gap_d   = '0;
                    state_d = StGap;
                end
            end
`endif
            StGap: begin
                if (gap_q == GapLast) begin
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = StIdle;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            len_q        <= 8'd0;
            rd_addr_q    <= 8'd0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'd0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            gap_q        <= '0;
`ifdef MODBUS_TX_CRC_EN
            crc_q        <= CRC_INIT;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            rd_addr_q    <= rd_addr_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            gap_q        <= gap_d;
`ifdef MODBUS_TX_CRC_EN
            crc_q        <= crc_d;
`endif
        end
    end

    assign rd_addr    = rd_addr_q;
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_modbus_frame_tx.sv
// Directed bench for modbus_frame_tx with a synchronous buffer model and a simple
// uart_byte_tx responder. Follows MODBUS_TX_CRC_EN the same way as the design.
module tb_modbus_frame_tx;

    localparam int unsigned GAP    = 100;
    localparam int          TX_LAT = 4;
`ifdef MODBUS_TX_CRC_EN
    localparam int          NCRC   = 2;
`else
    localparam int          NCRC   = 0;
`endif

    logic       sys_clk;
    logic       reset_n;
    logic       frame_start;
    logic [7:0] frame_len;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done = 1'b0;
    logic       busy;
    logic       frame_done;
    logic       frame_err;

    logic [7:0] mem [256];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] bytes_q[$];
    int         start_cyc_q[$];
    int         done_cyc_q[$];
    int         n_fd = 0, n_fe = 0, n_busy = 0, n_wide = 0, n_glitch = 0, n_busy_edge = 0;
    int         fd_cyc = 0;
    logic       prev_start = 1'b0, prev_busy = 1'b0;
    logic [7:0] prev_data = 8'h00;

    modbus_frame_tx #(
        .GAP_CYCLES (GAP)
    ) dut (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .frame_len   (frame_len),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_err   (frame_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Synchronous response buffer
    always @(posedge sys_clk) rd_data <= mem[rd_addr];

    // Byte transmitter stand-in: tx_done TX_LAT cycles after each tx_start
    always begin
        @(negedge sys_clk);
        if (tx_start && reset_n) begin
            repeat (TX_LAT) @(posedge sys_clk);
            #1 tx_done = 1'b1;
            @(posedge sys_clk);
            #1 tx_done = 1'b0;
        end
    end

    // Monitor on the falling edge, away from the active edge
    always @(negedge sys_clk) begin
        if (reset_n) begin
            if (tx_start) begin
                bytes_q.push_back(tx_data);
                start_cyc_q.push_back(cyc);
                if (prev_start) n_wide++;
            end else if (tx_data !== prev_data) begin
                n_glitch++;
            end
            if (tx_done) done_cyc_q.push_back(cyc);
            if (frame_done) begin
                n_fd++;
                fd_cyc = cyc;
                if (busy || !prev_busy) n_busy_edge++;
            end
            if (frame_err) n_fe++;
            if (busy) n_busy++;
        end
        prev_start = tx_start;
        prev_data  = tx_data;
        prev_busy  = busy;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] ref_crc(input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ mem[i][j];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] len, output int c);
        tick();
        frame_len   = len;
        frame_start = 1'b1;
        c           = cyc;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_fd(input int base, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (n_fd > base) ok = 1'b1;
        end
    endtask

    task automatic wait_starts(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (bytes_q.size() >= target) ok = 1'b1;
        end
    endtask

    task automatic load_req();
        mem[0] = 8'h01; mem[1] = 8'h03; mem[2] = 8'h00;
        mem[3] = 8'h00; mem[4] = 8'h00; mem[5] = 8'h0A;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        frame_start = 1'b0;
        frame_len   = 8'd0;
        repeat (3) tick();
        total += 6;
        if (rd_addr !== 8'd0)  begin bad++; $display("FAIL rst_rd_addr: got %0h want 0", rd_addr); end
        if (tx_start !== 1'b0) begin bad++; $display("FAIL rst_tx_start: got %0b want 0", tx_start); end
        if (tx_data !== 8'd0)  begin bad++; $display("FAIL rst_tx_data: got %0h want 0", tx_data); end
        if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
        if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done: got %0b want 0", frame_done); end
        if (frame_err !== 1'b0)  begin bad++; $display("FAIL rst_frame_err: got %0b want 0", frame_err); end
        reset_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_basic_frame();
        logic [7:0] exp [8] = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD};
        int nexp = 6 + NCRC;
        int b0 = bytes_q.size();
        int d0 = done_cyc_q.size();
        int f0 = n_fd;
        int c0;
        bit ok;
        load_req();
        pulse_start(8'd6, c0);
        wait_fd(f0, 2000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_timeout: got no frame_done want frame_done"); end
        total++;
        if (bytes_q.size() - b0 != nexp) begin
            bad++; $display("FAIL basic_count: got %0d want %0d", bytes_q.size() - b0, nexp);
        end else begin
            for (int i = 0; i < nexp; i++) begin
                total++;
                if (bytes_q[b0+i] !== exp[i]) begin
                    bad++; $display("FAIL basic_byte%0d: got %0h want %0h", i, bytes_q[b0+i], exp[i]);
                end
            end
            total += 3;
            if (start_cyc_q[b0] - c0 != 3) begin
                bad++; $display("FAIL start_latency: got %0d want 3", start_cyc_q[b0] - c0);
            end
            if (start_cyc_q[b0+1] - done_cyc_q[d0] != 3) begin
                bad++; $display("FAIL next_byte_latency: got %0d want 3",
                                start_cyc_q[b0+1] - done_cyc_q[d0]);
            end
            if (fd_cyc - done_cyc_q[d0+nexp-1] != int'(GAP) + 1) begin
                bad++; $display("FAIL gap_latency: got %0d want %0d",
                                fd_cyc - done_cyc_q[d0+nexp-1], GAP + 1);
            end
`ifdef MODBUS_TX_CRC_EN
            total++;
            if (start_cyc_q[b0+6] - done_cyc_q[d0+5] != 2) begin
                bad++; $display("FAIL crc_latency: got %0d want 2",
                                start_cyc_q[b0+6] - done_cyc_q[d0+5]);
            end
`endif
        end
        total += 2;
        if (n_fd - f0 != 1) begin bad++; $display("FAIL basic_frame_done: got %0d want 1", n_fd - f0); end
        if (busy !== 1'b0)  begin bad++; $display("FAIL basic_busy_end: got %0b want 0", busy); end
    endtask

`ifdef MODBUS_TX_CRC_EN
    task automatic test_len_bounds();
        logic [7:0] lens [2] = '{8'd0, 8'd255};
        int c;
        for (int k = 0; k < 2; k++) begin
            int e0 = n_fe;
            int s0 = bytes_q.size();
            int y0 = n_busy;
            pulse_start(lens[k], c);
            repeat (6) tick();
            total += 3;
            if (n_fe - e0 != 1) begin
                bad++; $display("FAIL len%0d_err: got %0d want 1", lens[k], n_fe - e0);
            end
            if (bytes_q.size() != s0) begin
                bad++; $display("FAIL len%0d_tx: got %0d want 0", lens[k], bytes_q.size() - s0);
            end
            if (n_busy != y0) begin
                bad++; $display("FAIL len%0d_busy: got %0d want 0", lens[k], n_busy - y0);
            end
        end
    endtask
`else
    task automatic test_len_bounds();
        logic [7:0] lens [2] = '{8'd255, 8'd0};
        int         want [2] = '{255, 256};
        int c;
        bit ok;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        for (int k = 0; k < 2; k++) begin
            int e0 = n_fe;
            int s0 = bytes_q.size();
            int f0 = n_fd;
            pulse_start(lens[k], c);
            wait_fd(f0, 5000, ok);
            total += 3;
            if (!ok) begin bad++; $display("FAIL len%0d_timeout: got no frame_done want frame_done", lens[k]); end
            if (n_fe != e0) begin bad++; $display("FAIL len%0d_err: got %0d want 0", lens[k], n_fe - e0); end
            if (bytes_q.size() - s0 != want[k]) begin
                bad++; $display("FAIL len%0d_count: got %0d want %0d", lens[k], bytes_q.size() - s0, want[k]);
            end else begin
                total++;
                if (bytes_q[s0+want[k]-1] !== mem[want[k]-1]) begin
                    bad++; $display("FAIL len%0d_last: got %0h want %0h", lens[k],
                                    bytes_q[s0+want[k]-1], mem[want[k]-1]);
                end
            end
        end
    endtask
`endif

    task automatic test_busy_ignore();
        logic [7:0] exp [8] = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD};
        int nexp = 6 + NCRC;
        int b0 = bytes_q.size();
        int f0 = n_fd;
        int e0 = n_fe;
        int c;
        bit ok;
        load_req();
        pulse_start(8'd6, c);
        wait_starts(b0 + 3, 500, ok);
        pulse_start(8'd2, c);
        wait_fd(f0, 2000, ok);
        repeat (10) tick();
        total += 4;
        if (!ok) begin bad++; $display("FAIL ignore_timeout: got no frame_done want frame_done"); end
        if (n_fd - f0 != 1) begin bad++; $display("FAIL ignore_frames: got %0d want 1", n_fd - f0); end
        if (n_fe != e0) begin bad++; $display("FAIL ignore_err: got %0d want 0", n_fe - e0); end
        if (bytes_q.size() - b0 != nexp) begin
            bad++; $display("FAIL ignore_count: got %0d want %0d", bytes_q.size() - b0, nexp);
        end else begin
            for (int i = 0; i < nexp; i++) begin
                total++;
                if (bytes_q[b0+i] !== exp[i]) begin
                    bad++; $display("FAIL ignore_byte%0d: got %0h want %0h", i, bytes_q[b0+i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int f0 = n_fd;
        int b0;
        int last_done;
        int c;
        bit ok;
        mem[0] = 8'hAB;
        mem[1] = 8'hCD;
        pulse_start(8'd2, c);
        wait_fd(f0, 2000, ok);
        last_done = done_cyc_q[done_cyc_q.size()-1];
        b0 = bytes_q.size();
        pulse_start(8'd2, c);
        wait_fd(f0 + 1, 2000, ok);
        total += 3;
        if (!ok) begin bad++; $display("FAIL b2b_timeout: got no frame_done want frame_done"); end
        if (bytes_q.size() - b0 != 2 + NCRC) begin
            bad++; $display("FAIL b2b_count: got %0d want %0d", bytes_q.size() - b0, 2 + NCRC);
        end else if (start_cyc_q[b0] - last_done < int'(GAP) + 3) begin
            bad++; $display("FAIL b2b_gap: got %0d want >=%0d", start_cyc_q[b0] - last_done, GAP + 3);
        end
        if (n_busy_edge != 0) begin
            bad++; $display("FAIL busy_vs_done: got %0d want 0", n_busy_edge);
        end
    endtask

    task automatic test_reset_mid();
        int b0 = bytes_q.size();
        int f0;
        int c;
        bit ok;
        load_req();
        pulse_start(8'd6, c);
        wait_starts(b0 + 2, 500, ok);
        reset_n = 1'b0;
        #1;
        total += 5;
        if (!ok) begin bad++; $display("FAIL mid_reach: got no byte2 want byte2"); end
        if (rd_addr !== 8'd0)  begin bad++; $display("FAIL mid_rd_addr: got %0h want 0", rd_addr); end
        if (tx_data !== 8'd0)  begin bad++; $display("FAIL mid_tx_data: got %0h want 0", tx_data); end
        if (busy !== 1'b0)     begin bad++; $display("FAIL mid_busy: got %0b want 0", busy); end
        if (tx_start !== 1'b0) begin bad++; $display("FAIL mid_tx_start: got %0b want 0", tx_start); end
        repeat (10) tick();
        reset_n = 1'b1;
        repeat (10) tick();
        b0 = bytes_q.size();
        f0 = n_fd;
        pulse_start(8'd6, c);
        wait_fd(f0, 2000, ok);
        total += 2;
        if (!ok) begin bad++; $display("FAIL mid_timeout: got no frame_done want frame_done"); end
        if (bytes_q.size() - b0 != 6 + NCRC) begin
            bad++; $display("FAIL mid_count: got %0d want %0d", bytes_q.size() - b0, 6 + NCRC);
        end else begin
            total++;
            if (bytes_q[b0+5] !== 8'h0A) begin
                bad++; $display("FAIL mid_last: got %0h want 0a", bytes_q[b0+5]);
            end
`ifdef MODBUS_TX_CRC_EN
            total++;
            if ({bytes_q[b0+7], bytes_q[b0+6]} !== 16'hCDC5) begin
                bad++; $display("FAIL mid_crc: got %0h want cdc5", {bytes_q[b0+7], bytes_q[b0+6]});
            end
`endif
        end
    endtask

    task automatic test_short_frame();
        logic [7:0] exp [3] = '{8'h11, 8'h22, 8'h33};
        int b0 = bytes_q.size();
        int f0 = n_fd;
        int c;
        bit ok;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
        pulse_start(8'd3, c);
        wait_fd(f0, 2000, ok);
        total += 2;
        if (!ok) begin bad++; $display("FAIL short_timeout: got no frame_done want frame_done"); end
        if (bytes_q.size() - b0 != 3 + NCRC) begin
            bad++; $display("FAIL short_count: got %0d want %0d", bytes_q.size() - b0, 3 + NCRC);
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (bytes_q[b0+i] !== exp[i]) begin
                    bad++; $display("FAIL short_byte%0d: got %0h want %0h", i, bytes_q[b0+i], exp[i]);
                end
            end
`ifdef MODBUS_TX_CRC_EN
            total++;
            if ({bytes_q[b0+4], bytes_q[b0+3]} !== ref_crc(3)) begin
                bad++; $display("FAIL short_crc: got %0h want %0h",
                                {bytes_q[b0+4], bytes_q[b0+3]}, ref_crc(3));
            end
`endif
        end
        total += 2;
        if (n_wide != 0)   begin bad++; $display("FAIL tx_start_width: got %0d want 0", n_wide); end
        if (n_glitch != 0) begin bad++; $display("FAIL tx_data_stable: got %0d want 0", n_glitch); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_basic_frame();
        test_len_bounds();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_short_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
